// File: rtl/scroll_controller_7seg.sv
// Scrolls a buffered message of 4-bit character codes across DIGITS 7-segment positions.
// Define SCROLL_CONTROLLER_LOOP_EN to repeat passes until stop instead of one pass.
module scroll_controller_7seg #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SHIFT_HZ = 2,
  parameter int DEPTH    = 16,
  parameter int DIGITS   = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_valid,
  input  logic [3:0]          wr_data,
  output logic                wr_ready,
  input  logic                clear,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*4-1:0] digit,
  output logic [DIGITS-1:0]   blank
);

  localparam int DIV = CLK_HZ / SHIFT_HZ;
  localparam int TW  = $clog2(DIV);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW  = $clog2(DEPTH + DIGITS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [3:0]    mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] eff_cnt;
  logic [RW-1:0] rd_idx;
  logic [RW-1:0] last_idx;
  logic [TW-1:0] tick;

  logic       hs;
  logic       enter;
  logic       leave;
  logic       shift;
  logic       wrap;
  logic       done_nx;
  logic       ld_blank;
  logic [3:0] ld_char;

  assign wr_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign busy     = (state == SCROLL);
  assign hs       = wr_valid && wr_ready;

  // A write landing in the same cycle as start counts; clear wipes everything.
  assign eff_cnt  = clear ? '0 : count + CW'(hs);
  assign last_idx = RW'(count) + RW'(DIGITS - 1);

  assign ld_blank = !(rd_idx < RW'(count));
  assign ld_char  = ld_blank ? 4'h0 : mem[rd_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    enter    = 1'b0;
    leave    = 1'b0;
    shift    = 1'b0;
    wrap     = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (eff_cnt != '0)) begin
          state_nx = SCROLL;
          enter    = 1'b1;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_nx = IDLE;
          leave    = 1'b1;
        end else if (tick == TW'(DIV - 1)) begin
          shift = 1'b1;
          if (rd_idx == last_idx) begin
            done_nx = 1'b1;
`ifdef SCROLL_CONTROLLER_LOOP_EN
            wrap = 1'b1;
`else
            state_nx = IDLE;
            leave    = 1'b1;
`endif
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= '0;
      rd_idx <= '0;
      tick   <= '0;
      digit  <= '0;
      blank  <= '1;
      done   <= 1'b0;
    end else begin
      done <= done_nx;
      if (state == IDLE) begin
        if (clear) begin
          count <= '0;
        end else if (hs) begin
          count <= count + CW'(1);
        end
      end
      if (enter || leave) begin
        tick   <= '0;
        rd_idx <= '0;
        digit  <= '0;
        blank  <= '1;
      end else if (state == SCROLL) begin
        tick <= shift ? '0 : tick + TW'(1);
        if (shift) begin
          digit  <= {digit[DIGITS*4-5:0], ld_char};
          blank  <= {blank[DIGITS-2:0], ld_blank};
          rd_idx <= wrap ? '0 : rd_idx + RW'(1);
        end
      end
    end
  end

  // Buffer contents need no reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (hs && !clear) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_scroll_controller_7seg.sv
// Randomised scoreboard bench for scroll_controller_7seg (DIV=4, DEPTH=4, DIGITS=6).
// Expected display frames come from a position/index model of the scrolling message.
module tb_scroll_controller_7seg;

  localparam int DEPTH  = 4;
  localparam int DIGITS = 6;
  localparam int DIV    = 4;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_data  = 4'h0;
  logic        clear    = 1'b0;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [23:0] digit;
  logic [5:0]  blank;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          cyc;
    logic [5:0]  blank;
    logic [23:0] digit;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] msg[$];

  scroll_controller_7seg #(
    .CLK_HZ  (8),
    .SHIFT_HZ(2),
    .DEPTH   (DEPTH),
    .DIGITS  (DIGITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .clear   (clear),
    .start   (start),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .digit   (digit),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] vis(input logic [23:0] d,
                                      input logic [5:0] b);
    logic [23:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++)
      if (b[i] !== 1'b0) r[4*i +: 4] = 4'h0;
    return r;
  endfunction

  // After k shifts, position i shows message character k-1-i when it exists.
  function automatic void frame(input int k,
                                output logic [5:0] b,
                                output logic [23:0] d);
    int n, len, kk, j;
    n   = msg.size();
    len = n + DIGITS;
    kk  = ((k - 1) % len) + 1;
    b   = '1;
    d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      j = kk - 1 - i;
      if (j >= 0 && j < n) begin
        b[i]       = 1'b0;
        d[4*i +: 4] = msg[j];
      end
    end
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  logic [5:0]  pb = '1;
  logic [23:0] pd = '0;

  always @(negedge clk) begin
    exp_t        e;
    logic [23:0] cd;
    bit          ok;
    cd = vis(digit, blank);
    if (mon_en && (blank !== pb || cd !== pd || done !== 1'b0)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cyc=%0d blank=%b digit=%h done=%b busy=%b, required no event",
                 cyc, blank, cd, done, busy);
      end else begin
        e  = exp_q.pop_front();
        ok = (cyc == e.cyc) && (blank === e.blank) &&
             (cd === vis(e.digit, e.blank)) &&
             (done === e.done) && (busy === e.busy);
        if (!ok) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d blank=%b digit=%h done=%b busy=%b, required cyc=%0d blank=%b digit=%h done=%b busy=%b",
                   cyc, blank, cd, done, busy,
                   e.cyc, e.blank, vis(e.digit, e.blank), e.done, e.busy);
        end
      end
    end
    pb = blank;
    pd = cd;
  end

  task automatic write_char(input logic [3:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    check("wr_ready", 32'(wr_ready), 32'(msg.size() < DEPTH));
    if (msg.size() < DEPTH) msg.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic clear_buf(input bit with_wr);
    clear    = 1'b1;
    wr_valid = with_wr;
    wr_data  = 4'($urandom_range(15));
    @(negedge clk);
    clear    = 1'b0;
    wr_valid = 1'b0;
    msg.delete();
  endtask

  task automatic idle_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_in_idle", 32'(busy), 32'd0);
  endtask

  // m_in < 0: run to the end of the pass; otherwise stop (or reset) after m_in shifts.
  task automatic scroll(input int m_in, input int off,
                        input bit with_wr, input bit by_rst);
    int          n, len, s0, m, stop_c, end_c;
    bit          full;
    exp_t        e;
    logic [5:0]  b;
    logic [23:0] d;
    start = 1'b1;
    if (with_wr) begin
      wr_valid = 1'b1;
      wr_data  = 4'($urandom_range(15));
      if (msg.size() < DEPTH) msg.push_back(wr_data);
    end
    n  = msg.size();
    s0 = cyc;
    @(negedge clk);
    start    = 1'b0;
    wr_valid = 1'b0;
    if (n == 0) begin
      check("empty_start_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      check("empty_start_idle", 32'(busy), 32'd0);
      return;
    end
    check("busy_rise", 32'(busy), 32'd1);
    check("ready_in_scroll", 32'(wr_ready), 32'd0);
    len  = n + DIGITS;
    m    = m_in;
    full = 1'b0;
    if (m < 0) begin
`ifdef SCROLL_CONTROLLER_LOOP_EN
      m   = 2 * len + 1;
      off = 0;
`else
      m    = len;
      full = 1'b1;
`endif
    end
    for (int k = 1; k <= m; k++) begin
      frame(k, b, d);
      e.cyc   = s0 + 1 + DIV * k;
      e.blank = b;
      e.digit = d;
      e.done  = (k % len == 0);
`ifdef SCROLL_CONTROLLER_LOOP_EN
      e.busy  = 1'b1;
`else
      e.busy  = (k != len);
`endif
      exp_q.push_back(e);
    end
    stop_c = s0 + 1 + DIV * m + off;
    end_c  = full ? (s0 + 1 + DIV * len) : (stop_c + 1);
    if (!full) begin
      e.cyc   = end_c;
      e.blank = '1;
      e.digit = '0;
      e.done  = 1'b0;
      e.busy  = 1'b0;
      exp_q.push_back(e);
    end
    while (cyc < end_c) begin
      wr_valid = 1'($urandom_range(1));
      wr_data  = 4'($urandom_range(15));
      clear    = 1'($urandom_range(1));
      start    = 1'($urandom_range(1));
      stop     = !full && !by_rst && (cyc == stop_c);
      reset_n  = !(by_rst && (cyc == stop_c));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    clear    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    if (by_rst) begin
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      msg.delete();
    end
  endtask

  initial begin
    int n, m, mode;
    bit wr;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_blank", 32'(blank), 32'h3f);
    check("reset_digit", 32'(digit), 32'd0);
    check("reset_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    write_char(4'd1);
    write_char(4'd2);
    write_char(4'd3);
    scroll(-1, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    clear_buf(1'b0);
    repeat (5) write_char(4'($urandom_range(15)));
    scroll(-1, 0, 1'b0, 1'b0);

    clear_buf(1'b0);
    scroll(-1, 0, 1'b0, 1'b0);

    write_char(4'd9);
    clear_buf(1'b1);
    scroll(-1, 0, 1'b0, 1'b0);

    write_char(4'd1);
    write_char(4'd2);
    write_char(4'd3);
    scroll(2, 0, 1'b0, 1'b0);
    idle_stop();
    scroll(-1, 0, 1'b0, 1'b0);

    scroll(3, 1, 1'b0, 1'b1);
    scroll(-1, 0, 1'b0, 1'b0);

    scroll(-1, 0, 1'b1, 1'b0);

`ifdef SCROLL_CONTROLLER_LOOP_EN
    clear_buf(1'b0);
    write_char(4'($urandom_range(15)));
    scroll(-1, 0, 1'b0, 1'b0);
`endif

    repeat (16) begin
      clear_buf(1'b0);
      n = $urandom_range(1, 5);
      repeat (n) write_char(4'($urandom_range(15)));
      mode = $urandom_range(0, 2);
      wr   = 1'($urandom_range(1));
      m    = $urandom_range(1, msg.size() + DIGITS - 1);
      if (mode == 0) scroll(-1, 0, wr, 1'b0);
      else scroll(m, $urandom_range(0, 3), wr, mode == 2);
      idle_stop();
    end

    repeat (8) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
